// File: rtl/en_strobe_gen.sv
// Programmable clock-enable generator: one-cycle en strobe every P cycles,
// free-running or as a burst of N strobes, with a valid/ready config port.
module en_strobe_gen #(
  parameter int DATA_WIDTH     = 8,
  parameter int DEFAULT_PERIOD = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DATA_WIDTH-1:0] cfg_period,
  input  logic [DATA_WIDTH-1:0] cfg_burst,
  input  logic                  start,
  input  logic                  stop,
  output logic                  en,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] pulses_left
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [DATA_WIDTH-1:0] ZERO = '0;
  localparam logic [DATA_WIDTH-1:0] ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DEF_PERIOD = DATA_WIDTH'(DEFAULT_PERIOD);

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] period_reg, period_next;
  logic [DATA_WIDTH-1:0] burst_reg, burst_next;
  logic [DATA_WIDTH-1:0] divider_reg, divider_next;
  logic [DATA_WIDTH-1:0] pulses_reg, pulses_next;
  logic                  en_reg, en_next;
  logic                  done_reg, done_next;

  logic                  handshake;
  logic [DATA_WIDTH-1:0] run_period, run_burst, eff_period;
  logic                  div_wrap;

  assign cfg_ready = rst && (state_reg == IDLE);
  assign handshake = cfg_valid && cfg_ready;

  // Config accepted in the start cycle takes effect for that same run.
  assign run_period = handshake ? cfg_period : period_reg;
  assign run_burst  = handshake ? cfg_burst  : burst_reg;
  assign eff_period = (run_period == ZERO) ? ONE : run_period;
  assign div_wrap   = (divider_reg == (eff_period - ONE));

  always_comb begin
    state_next   = state_reg;
    period_next  = run_period;
    burst_next   = run_burst;
    divider_next = divider_reg;
    pulses_next  = pulses_reg;
    en_next      = 1'b0;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        divider_next = ZERO;
        if (start && !stop) begin
          state_next  = RUN;
          en_next     = 1'b1;
          // The first strobe lands in the cycle right after start, so count it now.
          pulses_next = (run_burst == ZERO) ? ZERO : run_burst - ONE;
        end
      end
      RUN: begin
        if (stop) begin
          state_next   = IDLE;
          divider_next = ZERO;
        end else if (en_reg && (burst_reg != ZERO) && (pulses_reg == ZERO)) begin
          state_next   = IDLE;
          divider_next = ZERO;
          done_next    = 1'b1;
        end else begin
          divider_next = div_wrap ? ZERO : divider_reg + ONE;
          en_next      = div_wrap;
          if (div_wrap && (burst_reg != ZERO)) begin
            pulses_next = pulses_reg - ONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      period_reg  <= DEF_PERIOD;
      burst_reg   <= ZERO;
      divider_reg <= ZERO;
      pulses_reg  <= ZERO;
      en_reg      <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      period_reg  <= period_next;
      burst_reg   <= burst_next;
      divider_reg <= divider_next;
      pulses_reg  <= pulses_next;
      en_reg      <= en_next;
      done_reg    <= done_next;
    end
  end

  assign en          = en_reg;
  assign busy        = (state_reg == RUN);
  assign done        = done_reg;
  assign pulses_left = pulses_reg;

endmodule

// File: tb/tb_en_strobe_gen.sv
// Self-checking bench for en_strobe_gen: directed scenarios with literal
// expectations plus randomized traffic against a cycle-count reference model.
module tb_en_strobe_gen;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [DW-1:0] cfg_period = '0;
  logic [DW-1:0] cfg_burst = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          en, busy, done;
  logic [DW-1:0] pulses_left;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  en_strobe_gen #(.DATA_WIDTH(DW), .DEFAULT_PERIOD(1)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_burst(cfg_burst), .start(start), .stop(stop),
    .en(en), .busy(busy), .done(done), .pulses_left(pulses_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a run is described by its start cycle offset k,
  // period P, burst B and number of strobes issued so far.
  bit m_run, m_en, m_done;
  int m_per, m_bur, m_P, m_B, m_k, m_n, m_left;

  always @(posedge clk) begin
    if (!rst) begin
      m_run = 0; m_en = 0; m_done = 0; m_left = 0;
      m_per = 1; m_bur = 0; m_k = 0; m_n = 0; m_P = 1; m_B = 0;
    end else if (!m_run) begin
      m_done = 0;
      m_en   = 0;
      if (cfg_valid) begin
        m_per = int'(cfg_period);
        m_bur = int'(cfg_burst);
      end
      if (start && !stop) begin
        m_run  = 1;
        m_k    = 1;
        m_P    = (m_per == 0) ? 1 : m_per;
        m_B    = m_bur;
        m_n    = 1;
        m_en   = 1;
        m_left = (m_B == 0) ? 0 : m_B - m_n;
      end
    end else begin
      if (stop) begin
        m_run = 0;
        m_en  = 0;
      end else if (m_en && m_B != 0 && m_n == m_B) begin
        m_run  = 0;
        m_en   = 0;
        m_done = 1;
      end else begin
        m_k++;
        m_en = ((m_k - 1) % m_P) == 0;
        if (m_en) m_n++;
        m_left = (m_B == 0) ? 0 : m_B - m_n;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_en", int'(en), int'(m_en));
      chk("model_busy", int'(busy), int'(m_run));
      chk("model_done", int'(done), int'(m_done));
      chk("model_pulses_left", int'(pulses_left), m_left);
      chk("model_cfg_ready", int'(cfg_ready), int'(rst && !m_run));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset defaults
    rst = 1'b0;
    tick();
    chk_en = 1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_cfg_ready", int'(cfg_ready), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    tick();
    rst = 1'b1;
    #1;
    chk("post_rst_cfg_ready", int'(cfg_ready), 1);

    // Default period 1: strobe every cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("default_en", int'(en), 1);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    chk("default_stop_busy", int'(busy), 0);
    tick();

    // Burst: period 4, burst 3
    cfg_valid = 1'b1; cfg_period = 8'd4; cfg_burst = 8'd3;
    tick();
    cfg_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk("burst_en", int'(en), int'(k == 1 || k == 5 || k == 9));
      chk("burst_done", int'(done), int'(k == 10));
      chk("burst_busy", int'(busy), int'(k < 10));
      if (k == 1) chk("burst_left1", int'(pulses_left), 2);
      if (k == 5) chk("burst_left5", int'(pulses_left), 1);
      if (k == 9) chk("burst_left9", int'(pulses_left), 0);
      tick();
    end

    // Free-run period 3 with stop in cycle 5
    cfg_valid = 1'b1; cfg_period = 8'd3; cfg_burst = 8'd0;
    tick();
    cfg_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      stop = (k == 5);
      @(negedge clk);
      chk("free_en", int'(en), int'(k == 1 || k == 4));
      chk("free_done", int'(done), 0);
      chk("free_busy", int'(busy), int'(k <= 5));
      tick();
    end
    stop = 1'b0;

    // start+stop together in IDLE stays idle
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("start_stop_idle_busy", int'(busy), 0);
    tick();

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 199) != 0);
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_period = DW'($urandom_range(0, 6));
      cfg_burst  = DW'($urandom_range(0, 4));
      start      = ($urandom_range(0, 4) == 0);
      stop       = ($urandom_range(0, 24) == 0);
      tick();
    end
    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
